// File: rtl/data_bus_master_arbiter_if.sv
// Bus bundle for the two-master data bus arbiter.
//
// Carries both master-side request/response channels (m0 = core LSU, m1 = debug/DMA)
// and the single downstream request stream toward the address decoder and slaves.
//
// Modports:
//   arbiter : the arbiter itself (consumes master requests, drives the slave side)
//   master  : the two requesting masters (drive mN_req/payload, observe gnt/rvalid)
//   slave   : the decoder/slave side (observes s_req/payload, drives s_gnt/s_rvalid)
interface data_bus_master_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [3:0]  m0_be;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic        m1_we;
  logic [3:0]  m1_be;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic        s_req;
  logic        s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_gnt;
  logic        s_rvalid;
  logic [31:0] s_rdata;

  modport arbiter (
    input  m0_req, m0_we, m0_be, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_be, m1_addr, m1_wdata,
    input  s_gnt, s_rvalid, s_rdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output s_req, s_we, s_be, s_addr, s_wdata
  );

  modport master (
    output m0_req, m0_we, m0_be, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_be, m1_addr, m1_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err
  );

  modport slave (
    input  s_req, s_we, s_be, s_addr, s_wdata,
    output s_gnt, s_rvalid, s_rdata
  );
endinterface

// File: rtl/data_bus_master_arbiter.sv
// Two-master data bus arbiter.
//
// Shares the SoC data bus between the core load/store unit (master 0) and the
// debug/DMA port (master 1). At most one transaction is outstanding; each response is
// routed back to the master that was granted. A response watchdog returns an error
// response RESP_TIMEOUT cycles after the grant if the slave never answers.
//
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : data_bus_master_arbiter_if.arbiter (m0_*, m1_* master channels, s_* bus side)
//
// Parameters:
//   RESP_TIMEOUT : cycles from grant to watchdog error response, 1..255
//
// Configuration macro:
//   DATA_BUS_ARB_ROUND_ROBIN_EN : when defined, contention is resolved round-robin
//                                 (the master that did not own the last grant wins);
//                                 otherwise master 0 has fixed priority.
module data_bus_master_arbiter #(
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input logic                          clk,
  input logic                          rst_n,
  data_bus_master_arbiter_if.arbiter   bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [7:0] TimerLast = 8'(RESP_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_owner_q, last_owner_d;
  logic [7:0] timer_q, timer_d;

  logic any_req;
  logic winner;

  // Arbitration decision, only meaningful while idle.
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
    winner  = 1'b0;
`ifdef DATA_BUS_ARB_ROUND_ROBIN_EN
    if (bus.m0_req && bus.m1_req) begin
      winner = ~last_owner_q;
    end else begin
      winner = bus.m1_req;
    end
`else
    winner = ~bus.m0_req & bus.m1_req;
`endif
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    timer_d      = timer_q;

    bus.s_req     = 1'b0;
    bus.s_we      = 1'b0;
    bus.s_be      = 4'h0;
    bus.s_addr    = 32'h0;
    bus.s_wdata   = 32'h0;
    bus.m0_gnt    = 1'b0;
    bus.m1_gnt    = 1'b0;
    bus.m0_rvalid = 1'b0;
    bus.m0_rdata  = 32'h0;
    bus.m0_err    = 1'b0;
    bus.m1_rvalid = 1'b0;
    bus.m1_rdata  = 32'h0;
    bus.m1_err    = 1'b0;

    // Outputs are held at zero for the whole time reset is asserted.
    if (rst_n) begin
      unique case (state_q)
        StIdle: begin
          // A late s_rvalid here belongs to a timed-out transaction and is dropped.
          if (any_req) begin
            bus.s_req   = 1'b1;
            bus.s_we    = winner ? bus.m1_we    : bus.m0_we;
            bus.s_be    = winner ? bus.m1_be    : bus.m0_be;
            bus.s_addr  = winner ? bus.m1_addr  : bus.m0_addr;
            bus.s_wdata = winner ? bus.m1_wdata : bus.m0_wdata;
            if (bus.s_gnt) begin
              bus.m0_gnt   = ~winner;
              bus.m1_gnt   = winner;
              owner_d      = winner;
              last_owner_d = winner;
              timer_d      = 8'h0;
              state_d      = StBusy;
            end
          end
        end

        StBusy: begin
          timer_d = timer_q + 8'd1;
          // A real response beats the watchdog when both land in the same cycle.
          if (bus.s_rvalid) begin
            bus.m0_rvalid = ~owner_q;
            bus.m1_rvalid = owner_q;
            bus.m0_rdata  = owner_q ? 32'h0 : bus.s_rdata;
            bus.m1_rdata  = owner_q ? bus.s_rdata : 32'h0;
            state_d       = StIdle;
          end else if (timer_q == TimerLast) begin
            bus.m0_rvalid = ~owner_q;
            bus.m1_rvalid = owner_q;
            bus.m0_err    = ~owner_q;
            bus.m1_err    = owner_q;
            state_d       = StIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      timer_q      <= 8'h0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      timer_q      <= timer_d;
    end
  end

endmodule

// File: doc/data_bus_master_arbiter.md
# data_bus_master_arbiter

Two-master arbiter that shares the SoC data bus between the core load/store unit (master 0) and the debug/DMA port (master 1). It sits upstream of the data bus address decoder, which sees a single request stream. The arbiter serializes transactions with at most one outstanding request and routes each response back to the master that issued it. A response watchdog keeps a missing slave from hanging the bus.

## Interface
Parameters:
- RESP_TIMEOUT, 255: cycles to wait for `s_rvalid` after a grant before an error response is returned. Range 1..255. The counter is 8 bits.

Ports (`mN` = `m0`, `m1`):
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- mN_req  input  1  master request, held until `mN_gnt`
- mN_we  input  1  write enable
- mN_be  input  4  byte enables
- mN_addr  input  32  byte address
- mN_wdata  input  32  write data
- mN_gnt  output  1  request accepted this cycle
- mN_rvalid  output  1  response valid, one-cycle pulse
- mN_rdata  output  32  read data, valid with `mN_rvalid`
- mN_err  output  1  timeout error, valid with `mN_rvalid`
- s_req  output  1  request to the decoder and slaves
- s_we, s_be, s_addr, s_wdata  output  1/4/32/32  forwarded from the selected master
- s_gnt  input  1  slave accepted `s_req`
- s_rvalid  input  1  slave response valid
- s_rdata  input  32  slave read data

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - BUSY: one transaction granted and awaiting its response.
- Registers: `state`, `owner` (1 bit), `last_owner` (1 bit), `timer` (8 bits).
- IDLE behaviour:
  - Select the winner among the requesting masters: `s_req` = winner's req, and `s_we`, `s_be`, `s_addr`, `s_wdata` are muxed from the winner.
  - When `s_gnt` = 1: assert the winner's `mN_gnt` in the same cycle, set `owner` = winner and `last_owner` = winner, clear `timer`, then go to BUSY.
  - When no master requests: `s_req` = 0 and the `s_*` payload is driven 0.
- BUSY behaviour:
  - `s_req` = 0 and both `mN_gnt` = 0.
  - `timer` increments every cycle.
  - On `s_rvalid` = 1: drive the owner's `mN_rvalid` = 1, `mN_rdata` = `s_rdata`, `mN_err` = 0, then go to IDLE.
  - Otherwise, when `timer` == RESP_TIMEOUT-1: drive the owner's `mN_rvalid` = 1, `mN_rdata` = 0, `mN_err` = 1, then go to IDLE.
- An `s_rvalid` received in IDLE (a late response after a timeout) is discarded and never forwarded.
- The non-owner master's `rvalid`, `rdata` and `err` are always 0.
- Arbitration without the configuration macro: fixed priority, master 0 wins.

## Timing
- Reset values:
  - State: `state` = IDLE, `owner` = 0, `last_owner` = 1, `timer` = 0.
  - Outputs: all outputs 0.
- `mN_gnt` is combinational from `s_gnt` (zero-cycle grant). All other outputs are combinational from state plus inputs.
- Minimum transaction length is 2 cycles: grant in cycle T, response at T+1 at the earliest.
- The next grant can occur no earlier than the cycle after the response. The response cycle never overlaps a grant.
- A timeout response is issued exactly RESP_TIMEOUT cycles after the grant cycle.
- If `s_rvalid` arrives in the same cycle the timer expires, the real response wins and `err` = 0.
- An `rst_n` assertion mid-transaction immediately forces IDLE. The pending response is dropped.
- A master that drops `req` before `gnt` is a protocol violation; behaviour is unspecified.

## Configuration
- `DATA_BUS_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration. When both masters request in IDLE, the master ≠ `last_owner` wins. A single requester always wins.
- `DATA_BUS_ARB_ROUND_ROBIN_EN` undefined: fixed priority, master 0 wins. `last_owner` is still maintained but unused.

## Test plan
- Single read: m0 read to 0x0002_0000, `s_gnt` = 1, `s_rvalid` with 0xDEAD_BEEF two cycles later -> `m0_gnt` in the grant cycle, `m0_rvalid` = 1, `m0_rdata` = 0xDEAD_BEEF, `m0_err` = 0, nothing on m1.
- Contention, round robin on: m0 and m1 both request continuously, slave responds 1 cycle after grant -> grants alternate m0, m1, m0, m1, with each grant 2 cycles apart. With the macro off -> m0 is granted every time and m1 starves.
- Timeout: RESP_TIMEOUT = 4, m1 granted, no `s_rvalid` -> `m1_rvalid` = 1, `m1_err` = 1, `m1_rdata` = 0 exactly 4 cycles after the grant. A late `s_rvalid` one cycle later is not forwarded.
- Tie: `s_rvalid` arrives in the timer-expiry cycle -> `err` = 0 and data is forwarded.
- Slave stall: m0 requests with `s_gnt` = 0 for 3 cycles, then 1 -> `s_req` and `s_addr` are stable for all 4 cycles, and `m0_gnt` is asserted only in the 4th cycle.
- Reset in BUSY: assert `rst_n` = 0 one cycle after the grant -> all outputs 0 immediately. After release, the next request is served normally and the old `s_rvalid` is ignored.
